// File: rtl/acc2_core.sv
// acc2_core: accumulator Apollo core with an eight-opcode subset, one synchronous
// memory port and manual/automatic instruction stepping.
module acc2_core #(
    parameter int              AW           = 12,
    parameter logic [AW-1:0]   BOOT_ADDR    = 12'h800,
    parameter logic [14:0]     G_INIT       = 15'h2A00,
    parameter bit              DEFAULT_MODE = 1'b1,
    parameter int              TIMER_BITS   = 22
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          step,
    input  logic          mode_toggle,
    input  logic          disp_sel,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [15:0]   mem_din,
    output logic [15:0]   mem_dout,
    output logic [7:0]    leds,
    output logic          busy
);

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_OPLOAD
    } state_t;

    localparam logic [2:0] OP_TC   = 3'b000;
    localparam logic [2:0] OP_TCF  = 3'b001;
    localparam logic [2:0] OP_CA   = 3'b011;
    localparam logic [2:0] OP_CS   = 3'b100;
    localparam logic [2:0] OP_TS   = 3'b101;
    localparam logic [2:0] OP_AD   = 3'b110;
    localparam logic [2:0] OP_MASK = 3'b111;

    localparam logic [TIMER_BITS-1:0] TIMER_MATCH = {1'b1, {(TIMER_BITS-1){1'b0}}};

    state_t                state;
    logic [AW-1:0]         s;
    logic [AW-1:0]         q;
    logic [14:0]           g;
    logic [14:0]           a;
    logic                  mode;
    logic [TIMER_BITS-1:0] timer_cnt;

    logic [2:0]    opcode;
    logic [AW-1:0] k;
    logic          is_load;
    logic          timer_pulse;
    logic          step_event;
    logic          unused_din;

    assign opcode      = g[14:12];
    assign k           = g[AW-1:0];
    assign is_load     = (opcode == OP_CA) || (opcode == OP_CS) ||
                         (opcode == OP_AD) || (opcode == OP_MASK);
    assign timer_pulse = (timer_cnt == TIMER_MATCH);
    assign step_event  = mode ? step : timer_pulse;
    assign unused_din  = mem_din[15];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer_cnt <= '0;
        end else begin
            timer_cnt <= timer_cnt + 1'b1;
        end
    end

    // Events are only looked at in ST_WAIT; mode flips after this cycle's event check.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_WAIT;
            s     <= BOOT_ADDR;
            q     <= '0;
            g     <= G_INIT;
            a     <= '0;
            mode  <= DEFAULT_MODE;
        end else begin
            mode <= mode ^ mode_toggle;
            case (state)
                ST_WAIT: begin
                    if (step_event) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    g     <= mem_din[14:0];
                    s     <= s + 1'b1;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (opcode)
                        OP_TC: begin
                            q <= s;
                            s <= k;
                        end
                        OP_TCF:  s <= k;
                        default: ;
                    endcase
                    state <= is_load ? ST_OPLOAD : ST_WAIT;
                end
                ST_OPLOAD: begin
                    case (opcode)
                        OP_CA:   a <= mem_din[14:0];
                        OP_CS:   a <= ~mem_din[14:0];
                        OP_AD:   a <= a + mem_din[14:0];
                        OP_MASK: a <= a & mem_din[14:0];
                        default: ;
                    endcase
                    state <= ST_WAIT;
                end
                default: state <= ST_WAIT;
            endcase
        end
    end

    assign mem_addr = ((state == ST_EXEC) || (state == ST_OPLOAD)) ? k : s;
    assign mem_rd   = (state == ST_FETCH) || ((state == ST_EXEC) && is_load);
    assign mem_wr   = (state == ST_EXEC) && (opcode == OP_TS);
    assign mem_dout = {1'b0, a};
    assign leds     = {mode, disp_sel ? a[14:8] : g[14:8]};
    assign busy     = (state != ST_WAIT);

endmodule

// File: tb/tb_acc2_core.sv
// Directed self-checking bench for acc2_core with a 4096-word synchronous memory
// model and a 4-bit automatic timer.
module tb_acc2_core;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          step = 1'b0;
    logic          mode_toggle = 1'b0;
    logic          disp_sel = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [15:0]   mem_din;
    logic [15:0]   mem_dout;
    logic [7:0]    leds;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    acc2_core #(
        .AW(AW),
        .BOOT_ADDR(12'h800),
        .G_INIT(15'h2A00),
        .DEFAULT_MODE(1'b1),
        .TIMER_BITS(4)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .step(step),
        .mode_toggle(mode_toggle),
        .disp_sel(disp_sel),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .mem_wr(mem_wr),
        .mem_din(mem_din),
        .mem_dout(mem_dout),
        .leds(leds),
        .busy(busy)
    );

    // Memory model: one-cycle read latency, loaded by the bench through load_en.
    logic [15:0]   mem [0:4095];
    logic          clear_all = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [15:0]   load_data = '0;
    int            wr_cycles = 0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [15:0]   last_wr_data = '0;

    always @(posedge clk) begin
        if (clear_all) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'h2000;
        end else if (load_en) begin
            mem[load_addr] <= load_data;
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_dout;
            wr_cycles     <= wr_cycles + 1;
            last_wr_addr  <= mem_addr;
            last_wr_data  <= mem_dout;
        end
        if (mem_rd) mem_din <= mem[mem_addr];
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic loadWord(input logic [AW-1:0] addr, input logic [15:0] data);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (busy && cycles < 20) begin
            cycles++;
            @(negedge clk);
        end
        if (busy) checkOutput("busy_timeout", {31'b0, busy}, 32'h0);
    endtask

    task automatic applyStimulus(input logic do_step, input logic do_toggle, output int cycles);
        @(negedge clk);
        step        = do_step;
        mode_toggle = do_toggle;
        @(negedge clk);
        step        = 1'b0;
        mode_toggle = 1'b0;
        waitIdle(cycles);
    endtask

    initial begin
        int cyc;
        int rises;
        int w0;
        logic prev_busy;

        rstn      = 1'b0;
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        loadWord(12'h800, 16'h1805);
        loadWord(12'h805, 16'h0000);
        loadWord(12'h000, 16'h3100);
        loadWord(12'h001, 16'h6101);
        loadWord(12'h002, 16'h5102);
        loadWord(12'h003, 16'h4103);
        loadWord(12'h004, 16'h7104);
        loadWord(12'h005, 16'h6101);
        loadWord(12'h100, 16'h0003);
        loadWord(12'h101, 16'h7FFE);
        loadWord(12'h103, 16'h00F0);
        loadWord(12'h104, 16'h0F0F);

        checkOutput("rst_leds", {24'b0, leds}, 32'hAA);
        checkOutput("rst_busy", {31'b0, busy}, 32'h0);
        checkOutput("rst_rd", {31'b0, mem_rd}, 32'h0);
        checkOutput("rst_wr", {31'b0, mem_wr}, 32'h0);
        checkOutput("rst_addr", {20'b0, mem_addr}, 32'h800);
        checkOutput("rst_dout", {16'b0, mem_dout}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        applyStimulus(1'b1, 1'b0, cyc);
        checkOutput("tcf_cycles", cyc, 3);
        checkOutput("tcf_s", {20'b0, mem_addr}, 32'h805);
        checkOutput("tcf_leds", {24'b0, leds}, 32'h98);

        applyStimulus(1'b1, 1'b0, cyc);
        checkOutput("tc_s", {20'b0, mem_addr}, 32'h000);
        checkOutput("tc_q", {20'b0, dut.q}, 32'h806);

        applyStimulus(1'b1, 1'b0, cyc);
        checkOutput("ca_cycles", cyc, 4);
        checkOutput("ca_a", {16'b0, mem_dout}, 32'h0003);

        applyStimulus(1'b1, 1'b0, cyc);
        checkOutput("ad_wrap_a", {16'b0, mem_dout}, 32'h0001);

        w0 = wr_cycles;
        applyStimulus(1'b1, 1'b0, cyc);
        checkOutput("ts_cycles", cyc, 3);
        checkOutput("ts_wr_count", wr_cycles - w0, 1);
        checkOutput("ts_wr_addr", {20'b0, last_wr_addr}, 32'h102);
        checkOutput("ts_wr_data", {16'b0, last_wr_data}, 32'h0001);

        applyStimulus(1'b1, 1'b0, cyc);
        checkOutput("cs_a", {16'b0, mem_dout}, 32'h7F0F);

        applyStimulus(1'b1, 1'b0, cyc);
        checkOutput("mask_a", {16'b0, mem_dout}, 32'h0F0F);
        disp_sel = 1'b1;
        #1;
        checkOutput("disp_a_leds", {24'b0, leds}, 32'h8F);
        disp_sel = 1'b0;
        #1;
        checkOutput("disp_g_leds", {24'b0, leds}, 32'hF1);

        // Reset while the AD at 005 is in its operand-load cycle.
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("exec_rd", {31'b0, mem_rd}, 32'h1);
        checkOutput("exec_addr", {20'b0, mem_addr}, 32'h101);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checkOutput("mid_rst_rd", {31'b0, mem_rd}, 32'h0);
        checkOutput("mid_rst_busy", {31'b0, busy}, 32'h0);
        checkOutput("mid_rst_a", {16'b0, mem_dout}, 32'h0);
        checkOutput("mid_rst_addr", {20'b0, mem_addr}, 32'h800);
        @(negedge clk);
        rstn = 1'b1;
        loadWord(12'h800, 16'h1FFF);

        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        checkOutput("refetch_rd", {31'b0, mem_rd}, 32'h1);
        checkOutput("refetch_addr", {20'b0, mem_addr}, 32'h800);
        waitIdle(cyc);
        checkOutput("jump_fff", {20'b0, mem_addr}, 32'hFFF);
        applyStimulus(1'b1, 1'b0, cyc);
        checkOutput("s_wrap", {20'b0, mem_addr}, 32'h000);
        checkOutput("a_after_rst", {16'b0, mem_dout}, 32'h0);

        // Second step pulse lands in EXEC and must be dropped.
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("busy_step_idle", {31'b0, busy}, 32'h0);
        checkOutput("busy_step_s", {20'b0, mem_addr}, 32'h001);
        checkOutput("busy_step_a", {16'b0, mem_dout}, 32'h0003);

        applyStimulus(1'b1, 1'b1, cyc);
        checkOutput("toggle_step_s", {20'b0, mem_addr}, 32'h002);
        checkOutput("toggle_step_a", {16'b0, mem_dout}, 32'h0001);
        checkOutput("auto_mode_led", {31'b0, leds[7]}, 32'h0);

        w0 = wr_cycles;
        rises = 0;
        prev_busy = busy;
        for (int i = 0; i < 64; i++) begin
            step = ((i % 7) == 3);
            @(negedge clk);
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
        end
        step = 1'b0;
        waitIdle(cyc);
        checkOutput("auto_count", rises, 4);
        checkOutput("auto_s", {20'b0, mem_addr}, 32'h006);
        checkOutput("auto_a", {16'b0, mem_dout}, 32'h0F0D);
        checkOutput("auto_ts_count", wr_cycles - w0, 1);
        checkOutput("auto_mode_led2", {31'b0, leds[7]}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc2_core.md
# acc2_core

Parametrised Apollo CPU core, successor to the single-accumulator-less TCF/NOOP core. Adds an accumulator A and return register Q, plus an eight-opcode subset: TC, TCF, NOOP, CA, CS, TS, AD, MASK. It drives one synchronous-read/synchronous-write memory port and keeps the manual/automatic step modes with a parametrised automatic timer. Sits between the debounced front-panel buttons and the ROM/RAM address decoder. Its LEDs show either G or A plus the mode.

## Interface
- AW, 12, address width of S, of the operand field and of mem_addr
- BOOT_ADDR, 12'h800, reset value of S
- G_INIT, 15'h2A00, reset value of G
- DEFAULT_MODE, 1, reset mode (1 manual, 0 automatic)
- TIMER_BITS, 22, automatic-mode timer width; one event every 2^TIMER_BITS cycles
- clk  in  1  system clock, all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- step  in  1  debounced single-cycle pulse: next instruction (manual mode)
- mode_toggle  in  1  debounced single-cycle pulse: toggle manual/automatic
- disp_sel  in  1  0: leds[6:0]=G[14:8]; 1: leds[6:0]=A[14:8]
- mem_addr  out  AW  memory address
- mem_rd  out  1  read strobe; mem_din valid the cycle after
- mem_wr  out  1  write strobe; mem_dout written at this edge
- mem_din  in  16  read data (bit 15 ignored)
- mem_dout  out  16  write data, {1'b0, A}
- leds  out  8  {mode, 7 display bits}
- busy  out  1  1 whenever state != WAIT

## Operation
- Registers: S[AW-1:0], G[14:0], A[14:0], Q[AW-1:0], mode, 2..3-bit state, TIMER_BITS counter.
- G fields: opcode=G[14:12]; K=G[AW-1:0].
- Opcodes: 000 TC (Q<=S, S<=K); 001 TCF (S<=K); 010 NOOP; 011 CA (A<=M[K]); 100 CS (A<=~M[K]); 101 TS (M[K]<=A); 110 AD (A<=A+M[K], mod 2^15, carry discarded); 111 MASK (A<=A&M[K]).
- FSM states:
  - WAIT: outputs idle. event -> FETCH.
  - FETCH: mem_addr=S, mem_rd=1 -> DECODE.
  - DECODE: G<=mem_din[14:0], S<=S+1 (wraps at 2^AW) -> EXEC.
  - EXEC:
    - TC/TCF/NOOP: update per opcode -> WAIT.
    - TS: mem_addr=K, mem_wr=1 -> WAIT.
    - CA/CS/AD/MASK: mem_addr=K, mem_rd=1 -> OPLOAD.
  - OPLOAD: A updated from mem_din[14:0] -> WAIT.
- event = mode ? step : timer_pulse. Sampled only in WAIT; events in any other state are dropped, never queued.
- Timer: free-running counter, always enabled. timer_pulse=1 for exactly one cycle when counter == 2^(TIMER_BITS-1).
- mode toggles on each mode_toggle pulse.
- In-cycle event evaluation uses the pre-toggle mode.
- mem_addr = S in FETCH, K in EXEC/OPLOAD, S otherwise. mem_rd/mem_wr never both 1.
- Reset (async, any state, mid-instruction included) sets:
  - S=BOOT_ADDR, G=G_INIT, A=0, Q=0, mode=DEFAULT_MODE, counter=0, state=WAIT.
  - mem_rd=mem_wr=0 and busy=0 immediately (outputs decoded from state).
  - A partially executed instruction has no effect after reset.

## Timing
- Event in WAIT at edge t:
  - FETCH in cycle t+1, DECODE t+2, EXEC t+3.
  - WAIT at t+4 for TC/TCF/NOOP/TS; OPLOAD t+4, then WAIT at t+5 for CA/CS/AD/MASK.
- Memory latency is 1: data for a mem_rd in cycle n is sampled on the edge ending cycle n+1.
- TS write occurs on the edge ending EXEC.
- Register updates become visible on leds the cycle after the updating edge.
- Minimum spacing between accepted manual steps: 4 or 5 cycles. Automatic period 2^TIMER_BITS >> 5, so no timer event is ever lost in normal use.
- Wrap: S=2^AW-1 fetch -> S=0. AD 15'h7FFF+1 -> 0.

## Test plan
- Reset, manual mode: ROM[800]=1805 (TCF 805), ROM[805]=0000. Step -> S=805, G=1805, leds[6:0]=7'h18. Step -> Q=806, S=000.
- CA/AD/TS chain: M[100]=0003, M[101]=7FFE. Program CA 100; AD 101; TS 102. -> A=0001 (wrap), write 0001 to address 102 with mem_wr for exactly one cycle.
- CS/MASK: M[100]=00F0, M[101]=0F0F. CS 100 -> A=7F0F; MASK 101 -> A=0F0F. With disp_sel=1, leds[6:0]=7'h0F.
- Mode: mode_toggle and step in the same cycle -> that step executes; then automatic. TIMER_BITS=4 -> one instruction every 16 cycles; step pulses ignored; leds[7]=0.
- Step pulse while busy (e.g. in EXEC) -> ignored; no extra fetch, S unchanged afterwards.
- Assert rstn low during OPLOAD of AD -> A=0, S=BOOT_ADDR, mem_rd=0 immediately. After release, the first step refetches BOOT_ADDR.
